mm_tile_multiplier: RTL and testbench
=====================================

MM_TILE_MULTIPLIER -- requirements
Module: mm_tile_multiplier

Interface
REQ-001 SHALL have parameter L_DIM, default 3, meaning log2 of max matrix dimension D=2^L_DIM.
REQ-002 SHALL have parameter BITWIDTH, default 32, meaning signed element width.
REQ-003 SHALL have ports in this order, clock and reset first:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  in  1: one-cycle request to begin a job; sampled only in IDLE.
REQ-005 SHALL have cfg_m, cfg_k, cfg_n  in  L_DIM+1 each: rows of A, inner dim, cols of B; legal range 1..D.
REQ-006 SHALL have cfg_acc  in  1: 1 = C += A*B; 0 = C = A*B.
REQ-007 SHALL have rdaddr  out  2*L_DIM+2: memory read address; rddata is valid exactly 1 cycle after rdaddr.
REQ-008 SHALL have rddata  in  BITWIDTH: read data.
REQ-009 SHALL have wraddr  out  2*L_DIM+2, wrdata  out  BITWIDTH, and we  out  1: write port, committed on the clk edge while we=1.
REQ-010 SHALL have busy  out  1, done  out  1 and err  out  1: status.

Function
REQ-011 SHALL use row stride D for the memory map: A[i][k]=i*D+k; B[k][j]=D*D+k*D+j; C[i][j]=2*D*D+i*D+j.
REQ-012 SHALL latch cfg_* on the accepted start; changes to cfg_* during a job SHALL have no effect.
REQ-013 SHALL implement states IDLE, LOAD_ROW, CALC, ACC_RD, WRITE, DONE.
REQ-014 IDLE->LOAD_ROW on start when all cfg dims are legal. If any dim is 0 or >D: IDLE->DONE with err=1, and no memory write.
REQ-015 LOAD_ROW SHALL last cfg_k+1 cycles:
- issues reads A[i][0..K-1] on consecutive cycles;
- stores the returning data into an internal D-entry row buffer.
REQ-016 CALC SHALL last cfg_k+1 cycles per output element (i,j):
- issues B[0..K-1][j] reads;
- multiplies each returning word with rowbuf[k];
- sums the products in an accumulator.
REQ-017 The accumulator SHALL be signed, 2*BITWIDTH+L_DIM bits, and cleared at the start of each element.
REQ-018 When cfg_acc=1, CALC->ACC_RD (1 cycle, issues read of C[i][j]) -> WRITE, and the returned C value SHALL be added to the accumulator. When cfg_acc=0, CALC->WRITE.
REQ-019 WRITE SHALL last 1 cycle: we=1, wraddr=C[i][j], wrdata = accumulator saturated to signed BITWIDTH range.
REQ-020 Sequencing after WRITE:
- next j if j<N-1, else next row (LOAD_ROW) if i<M-1, else DONE.
REQ-021 DONE SHALL last exactly 1 cycle with done=1, then go to IDLE. err SHALL hold its value until the next accepted start.
REQ-022 busy SHALL be 1 in every state except IDLE, and start SHALL be ignored while busy=1.
REQ-023 rdaddr SHALL be 0 when no read is issued. wraddr and wrdata SHALL be 0 when we=0.
REQ-024 Total job latency from the start cycle to the done cycle SHALL be M*((K+1)+N*(K+2+cfg_acc)) + 1 cycles.
REQ-025 Row-buffer entries k>=K SHALL never contribute to any result.

Reset
REQ-026 While reset=1:
- state=IDLE;
- busy=done=err=we=0 and rdaddr=wraddr=wrdata=0;
- counters and accumulator cleared.
REQ-027 Reset asserted mid-job SHALL abort the job immediately, with no further writes; memory contents are left as-is.
REQ-028 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 Identity test, D=8, M=K=N=2, acc=0: A=[[1,2],[3,4]], B=I -> C=[[1,2],[3,4]] written at addresses 128,129,136,137; done 1 cycle after latency 2*(3+2*4)+1=23 cycles.
REQ-030 Accumulate, M=K=N=1, acc=1: A=3, B=-5, initial C=10 -> C=-5; exactly one write, at address 128.
REQ-031 Saturation, BITWIDTH=8, K=2: A=[127,127], B=[127,127] -> wrdata=127; negated A -> -128.
REQ-032 Illegal config cfg_k=0 -> done=1 and err=1 on the cycle after start, with we never asserted. The next legal job -> err=0.
REQ-033 Reset pulse during CALC of element (0,1) -> busy, we and done are 0 immediately; C[0][1] is not written.
REQ-034 Full size, M=K=N=8, random signed data -> all 64 C words match a reference model. start pulsed while busy is ignored.

Source files
------------

// File: rtl/mm_tile_multiplier.sv
// Tiled signed matrix multiplier: C = A*B (or C += A*B) over a shared single-port-read memory.
// A, B and C live at fixed bases with row stride D; one output element is produced per CALC/WRITE pass.
module mm_tile_multiplier #(
    parameter int L_DIM    = 3,
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [L_DIM:0]      cfg_m,
    input  logic [L_DIM:0]      cfg_k,
    input  logic [L_DIM:0]      cfg_n,
    input  logic                cfg_acc,
    output logic [2*L_DIM+1:0]  rdaddr,
    input  logic [BITWIDTH-1:0] rddata,
    output logic [2*L_DIM+1:0]  wraddr,
    output logic [BITWIDTH-1:0] wrdata,
    output logic                we,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int D    = 1 << L_DIM;
    localparam int ACCW = 2 * BITWIDTH + L_DIM;
    localparam logic [L_DIM:0] D_CFG = {1'b1, {L_DIM{1'b0}}};
    localparam logic [L_DIM:0] ONE   = {{L_DIM{1'b0}}, 1'b1};
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ROW,
        CALC,
        ACC_RD,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [L_DIM:0]               m_q, k_q, n_q;
    logic                         acc_q;
    logic                         err_q;
    logic [L_DIM:0]               cnt;
    logic [L_DIM-1:0]             row, col;
    logic signed [ACCW-1:0]       accum;
    logic signed [BITWIDTH-1:0]   rowbuf [D];

    logic                         cfg_ok;
    logic                         cnt_last, col_last, row_last, issue_rd;
    logic [L_DIM-1:0]             buf_idx;
    logic signed [BITWIDTH-1:0]   buf_word;
    logic signed [2*BITWIDTH-1:0] a_ext, b_ext, product;
    logic signed [ACCW-1:0]       prod_ext, c_ext, wr_sum;
    logic [BITWIDTH-1:0]          sat_word;

    assign cfg_ok = (cfg_m != '0) && (cfg_m <= D_CFG) &&
                    (cfg_k != '0) && (cfg_k <= D_CFG) &&
                    (cfg_n != '0) && (cfg_n <= D_CFG);

    assign cnt_last = (cnt == k_q);
    assign issue_rd = (cnt < k_q);
    assign col_last = ({1'b0, col} == (n_q - ONE));
    assign row_last = ({1'b0, row} == (m_q - ONE));

    // Data returning in count c belongs to the read issued in count c-1; modular
    // wrap of the low bits maps count D back onto entry D-1.
    assign buf_idx  = cnt[L_DIM-1:0] - L_DIM'(1);
    assign buf_word = rowbuf[buf_idx];
    assign a_ext    = {{BITWIDTH{rddata[BITWIDTH-1]}}, rddata};
    assign b_ext    = {{BITWIDTH{buf_word[BITWIDTH-1]}}, buf_word};
    assign product  = a_ext * b_ext;
    assign prod_ext = {{L_DIM{product[2*BITWIDTH-1]}}, product};
    assign c_ext    = acc_q ? {{(ACCW-BITWIDTH){rddata[BITWIDTH-1]}}, rddata} : '0;
    assign wr_sum   = accum + c_ext;

    always_comb begin
        sat_word = wr_sum[BITWIDTH-1:0];
        if (wr_sum > SAT_MAX) begin
            sat_word = SAT_MAX[BITWIDTH-1:0];
        end else if (wr_sum < SAT_MIN) begin
            sat_word = SAT_MIN[BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rdaddr     = '0;
        wraddr     = '0;
        wrdata     = '0;
        we         = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = cfg_ok ? LOAD_ROW : DONE;
                end
            end
            LOAD_ROW: begin
                if (issue_rd) begin
                    rdaddr = {2'b00, row, cnt[L_DIM-1:0]};
                end
                if (cnt_last) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (issue_rd) begin
                    rdaddr = {2'b01, cnt[L_DIM-1:0], col};
                end
                if (cnt_last) begin
                    state_next = acc_q ? ACC_RD : WRITE;
                end
            end
            ACC_RD: begin
                rdaddr     = {2'b10, row, col};
                state_next = WRITE;
            end
            WRITE: begin
                we     = 1'b1;
                wraddr = {2'b10, row, col};
                wrdata = sat_word;
                if (!col_last) begin
                    state_next = CALC;
                end else if (!row_last) begin
                    state_next = LOAD_ROW;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job configuration, loop indices and the dot-product accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q   <= '0;
            k_q   <= '0;
            n_q   <= '0;
            acc_q <= 1'b0;
            err_q <= 1'b0;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
            accum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q <= !cfg_ok;
                        m_q   <= cfg_m;
                        k_q   <= cfg_k;
                        n_q   <= cfg_n;
                        acc_q <= cfg_acc;
                        cnt   <= '0;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                LOAD_ROW: begin
                    cnt <= cnt_last ? '0 : cnt + ONE;
                end
                CALC: begin
                    cnt   <= cnt_last ? '0 : cnt + ONE;
                    accum <= (cnt == '0) ? '0 : accum + prod_ext;
                end
                WRITE: begin
                    if (!col_last) begin
                        col <= col + L_DIM'(1);
                    end else begin
                        col <= '0;
                        row <= row + L_DIM'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD_ROW && cnt != '0) begin
            rowbuf[buf_idx] <= rddata;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_mm_tile_multiplier.sv
// Self-checking bench: random matrices against a plain-arithmetic model of C = sat(A*B [+ C]).
// Memory is modelled in the bench; every DUT write is compared in order against the model's queue.
module tb_mm_tile_multiplier;

    localparam int L  = 3;
    localparam int BW = 8;
    localparam int AW = 2 * L + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [L:0]    cfg_m = 4'd1, cfg_k = 4'd1, cfg_n = 4'd1;
    logic          cfg_acc = 1'b0;
    logic [AW-1:0] rdaddr, wraddr;
    logic [BW-1:0] rddata, wrdata;
    logic          we, busy, done, err;

    logic [7:0]    mem [256];
    logic [7:0]    img [256];
    logic          loadReq = 1'b0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t expQ[$];
    wr_t expItem;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;
    int lastLatency = 0;

    mm_tile_multiplier #(.L_DIM(L), .BITWIDTH(BW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_acc(cfg_acc),
        .rdaddr(rdaddr), .rddata(rddata),
        .wraddr(wraddr), .wrdata(wrdata), .we(we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rddata <= mem[rdaddr];
        if (loadReq) begin
            mem <= img;
        end else if (we) begin
            mem[wraddr] <= wrdata;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Write-port compare: pending expected writes are dropped when reset aborts a job.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
        end
        if (we) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected write", 1, 0);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("wraddr", int'(wraddr), expItem.addr);
                checkOutput("wrdata", sx(wrdata), expItem.data);
            end
        end else begin
            checkOutput("write bus idle", int'({wraddr, wrdata}), 0);
        end
        if (!busy) begin
            checkOutput("rdaddr idle", int'(rdaddr), 0);
        end
    end

    task automatic buildExpected(input int m, input int k, input int n, input int acc);
        wr_t w;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                int s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    s += sx(img[i*8 + kk]) * sx(img[64 + kk*8 + j]);
                end
                if (acc != 0) s += sx(img[128 + i*8 + j]);
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                w.addr = 128 + i*8 + j;
                w.data = s;
                expQ.push_back(w);
            end
        end
    endtask

    task automatic loadImage();
        @(negedge clk);
        loadReq = 1'b1;
        @(negedge clk);
        loadReq = 1'b0;
    endtask

    task automatic fillImage(input int mode);
        for (int a = 0; a < 256; a++) begin
            if (mode == 0) img[a] = 8'h00;
            else if (mode == 1) img[a] = 8'(int'($urandom_range(0, 40)) - 20);
            else img[a] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic applyStimulus(input int m, input int k, input int n, input int acc,
                                 input int expErr, input int pulseMid);
        int elapsed;
        int expLat;
        expLat = (expErr != 0) ? 1 : m * ((k + 1) + n * (k + 2 + acc)) + 1;
        if (expErr == 0) buildExpected(m, k, n, acc);
        @(negedge clk);
        cfg_m = 4'(m);
        cfg_k = 4'(k);
        cfg_n = 4'(n);
        cfg_acc = 1'(acc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        elapsed = 1;
        while (!done && elapsed < 2000) begin
            checkOutput("busy during job", int'(busy), 1);
            if (pulseMid != 0 && elapsed == 5) begin
                start = 1'b1;
                cfg_k = 4'd0;
                cfg_m = 4'd1;
                cfg_acc = ~cfg_acc;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            elapsed++;
        end
        start = 1'b0;
        lastLatency = elapsed;
        checkOutput("done seen", int'(done), 1);
        checkOutput("latency", elapsed, expLat);
        checkOutput("err at done", int'(err), expErr);
        checkOutput("busy in done", int'(busy), 1);
        @(negedge clk);
        checkOutput("busy after done", int'(busy), 0);
        checkOutput("done one cycle", int'(done), 0);
        checkOutput("err held", int'(err), expErr);
        checkOutput("writes outstanding", expQ.size(), 0);
    endtask

    initial begin
        int w0;
        fillImage(0);
        loadReq = 1'b1;
        repeat (3) @(negedge clk);
        loadReq = 1'b0;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset err", int'(err), 0);
        checkOutput("reset we", int'(we), 0);
        checkOutput("reset rdaddr", int'(rdaddr), 0);
        reset = 1'b0;

        // Identity: A=[[1,2],[3,4]], B=I
        fillImage(0);
        img[0] = 8'd1; img[1] = 8'd2; img[8] = 8'd3; img[9] = 8'd4;
        img[64] = 8'd1; img[73] = 8'd1;
        loadImage();
        applyStimulus(2, 2, 2, 0, 0, 0);
        checkOutput("identity latency", lastLatency, 23);
        checkOutput("identity C00", sx(mem[128]), 1);
        checkOutput("identity C01", sx(mem[129]), 2);
        checkOutput("identity C10", sx(mem[136]), 3);
        checkOutput("identity C11", sx(mem[137]), 4);

        // Accumulate: 10 + 3*(-5) = -5
        fillImage(0);
        img[0] = 8'd3; img[64] = 8'hFB; img[128] = 8'd10;
        loadImage();
        w0 = writeCount;
        applyStimulus(1, 1, 1, 1, 0, 0);
        checkOutput("acc C00", sx(mem[128]), -5);
        checkOutput("acc write count", writeCount - w0, 1);

        // Saturation both ways
        fillImage(0);
        img[0] = 8'd127; img[1] = 8'd127; img[64] = 8'd127; img[72] = 8'd127;
        loadImage();
        applyStimulus(1, 2, 1, 0, 0, 0);
        checkOutput("sat positive", sx(mem[128]), 127);
        img[0] = 8'h81; img[1] = 8'h81;
        loadImage();
        applyStimulus(1, 2, 1, 0, 0, 0);
        checkOutput("sat negative", sx(mem[128]), -128);

        // Illegal configurations
        w0 = writeCount;
        applyStimulus(2, 0, 2, 0, 1, 0);
        applyStimulus(9, 1, 1, 1, 1, 0);
        repeat (3) @(negedge clk);
        checkOutput("err holds in idle", int'(err), 1);
        checkOutput("illegal no writes", writeCount - w0, 0);
        fillImage(1);
        loadImage();
        applyStimulus(1, 3, 2, 0, 0, 0);

        // Reset during CALC of element (0,1)
        fillImage(1);
        img[129] = 8'd55;
        loadImage();
        buildExpected(2, 2, 2, 0);
        w0 = writeCount;
        @(negedge clk);
        cfg_m = 4'd2; cfg_k = 4'd2; cfg_n = 4'd2; cfg_acc = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("busy before abort", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort we", int'(we), 0);
        checkOutput("abort done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort write count", writeCount - w0, 1);
        checkOutput("abort C01 untouched", sx(mem[129]), 55);

        // Random jobs, then full-size jobs with a start pulse while busy
        for (int t = 0; t < 8; t++) begin
            fillImage(1 + (t % 2));
            loadImage();
            applyStimulus(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                          int'($urandom_range(1, 8)), int'($urandom_range(0, 1)), 0, 0);
        end
        fillImage(1);
        loadImage();
        applyStimulus(8, 8, 8, 0, 0, 1);
        fillImage(2);
        loadImage();
        applyStimulus(8, 8, 8, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
